// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM with retired-instruction counter and memory-wait timeout.
// Optional BNE support is enabled by defining MC_BNE_EN.
module mc_controller #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic             zero_in,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             IorD,
   output logic             alu_src_a,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       reg_dst,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_op,
   output logic             branch_ne,
   output logic [4:0]       state,
   output logic             busy,
   output logic [CNT_W-1:0] retired,
   output logic             trap
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [4:0] {
      S_FETCH    = 5'd0,  S_DECODE   = 5'd1,  S_MEM_ADDR = 5'd2,  S_MEM_RD   = 5'd3,
      S_MEM_WB   = 5'd4,  S_MEM_WR   = 5'd5,  S_R_EXE    = 5'd6,  S_R_WB     = 5'd7,
      S_BEQ      = 5'd8,  S_J        = 5'd9,  S_JAL_WB   = 5'd10, S_JAL_J    = 5'd11,
      S_JR       = 5'd12, S_SLTI_EXE = 5'd13, S_SLTI_WB  = 5'd14, S_ADDI_EXE = 5'd15,
      S_ADDI_WB  = 5'd16, S_BNE      = 5'd17, S_TRAP     = 5'd31
   } state_t;

   state_t            state_q;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_hit;
   logic              retire_c;

   // The controller only sequences; func and zero_in are consumed by the datapath.
   logic unused_ok;
   assign unused_ok = ^{func, zero_in};

   assign state    = state_q;
   assign wait_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
   assign retire_c = (state_q != S_FETCH) && (state_q != S_TRAP) && (state_next == S_FETCH);

   // Next-state and strobe decode; an ack always beats a timeout in the same cycle.
   always_comb begin
      state_next    = state_q;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      IorD          = 1'b0;
      alu_src_a     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_b     = 2'b00;
      reg_dst       = 2'b00;
      pc_src        = 2'b00;
      alu_op        = 2'b00;
      branch_ne     = 1'b0;
      busy          = (state_q != S_FETCH);
      trap          = (state_q == S_TRAP);
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ack) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end else if (wait_hit) begin
               state_next = S_TRAP;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               6'b000000: state_next = S_R_EXE;
               6'b100011,
               6'b101011: state_next = S_MEM_ADDR;
               6'b000100: state_next = S_BEQ;
               6'b000010: state_next = S_J;
               6'b000011: state_next = S_JAL_WB;
               6'b000110: state_next = S_JR;
               6'b001010: state_next = S_SLTI_EXE;
               6'b001001: state_next = S_ADDI_EXE;
`ifdef MC_BNE_EN
               6'b000101: state_next = S_BNE;
`else
               6'b000101: state_next = S_TRAP;
`endif
               default:   state_next = S_TRAP;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = (opcode == 6'b100011) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
            if (mem_ack)       state_next = S_MEM_WB;
            else if (wait_hit) state_next = S_TRAP;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            IorD    = 1'b1;
            if (mem_ack)       state_next = S_FETCH;
            else if (wait_hit) state_next = S_TRAP;
         end
         S_R_EXE: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b10;
            state_next = S_R_WB;
         end
         S_R_WB: begin
            reg_dst    = 2'b01;
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end
         S_BEQ, S_BNE: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 2'b10;
`ifdef MC_BNE_EN
            branch_ne     = (state_q == S_BNE);
`endif
            state_next    = S_FETCH;
         end
         S_J, S_JAL_J: begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            state_next = S_FETCH;
         end
         S_JAL_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            state_next = S_JAL_J;
         end
         S_JR: begin
            pc_write   = 1'b1;
            pc_src     = 2'b11;
            state_next = S_FETCH;
         end
         S_SLTI_EXE, S_ADDI_EXE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alu_op     = (state_q == S_SLTI_EXE) ? 2'b11 : 2'b00;
            state_next = (state_q == S_SLTI_EXE) ? S_SLTI_WB : S_ADDI_WB;
         end
         S_SLTI_WB, S_ADDI_WB: begin
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end
         S_TRAP:  state_next = S_TRAP;
         default: state_next = S_TRAP;
      endcase
   end

   // Wait counter restarts whenever the state changes, so each memory state starts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         retired  <= '0;
         wait_cnt <= '0;
      end else begin
         state_q <= state_next;
         if (retire_c) retired <= retired + CNT_W'(1);
         if (state_next != state_q)
            wait_cnt <= '0;
         else if (mem_req && !mem_ack && (wait_cnt != '1))
            wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: expected per-cycle state/strobes/retired are queued, then replayed.
module tb_mc_controller;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned TMO   = 4;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011,
                          OP_JR = 6'b000110, OP_SLTI = 6'b001010, OP_ADDI = 6'b001001,
                          OP_BNE = 6'b000101, OP_BAD = 6'b111111;

   logic clk = 1'b0;
   logic rst, mem_ack, zero_in;
   logic [5:0] opcode, func;
   logic mem_req, mem_we, ir_write, pc_write, pc_write_cond, iord, alu_src_a, mem_to_reg, reg_write;
   logic [1:0] alu_src_b, reg_dst, pc_src, alu_op;
   logic branch_ne, busy, trap;
   logic [4:0] state;
   logic [CNT_W-1:0] retired;
   logic [19:0] ctrl;

   typedef struct {
      logic [4:0]       st;
      logic             ack;
      logic [5:0]       op;
      logic             rs;
      logic [CNT_W-1:0] ret;
   } item_t;

   item_t            q[$];
   logic [5:0]       cur_op;
   logic [CNT_W-1:0] model_ret;
   int               n_chk = 0;
   int               n_fail = 0;

   always #5 clk = ~clk;

   mc_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero_in(zero_in), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .IorD(iord), .alu_src_a(alu_src_a), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_b(alu_src_b), .reg_dst(reg_dst), .pc_src(pc_src),
      .alu_op(alu_op), .branch_ne(branch_ne), .state(state), .busy(busy), .retired(retired),
      .trap(trap)
   );

   assign ctrl = {mem_req, mem_we, ir_write, pc_write, pc_write_cond, iord, alu_src_a, mem_to_reg,
                  reg_write, alu_src_b, reg_dst, pc_src, alu_op, branch_ne, busy, trap};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected strobes for a state, written from the state table.
   function automatic logic [19:0] exp_ctrl(input logic [4:0] st, input logic ack);
      logic req, we, irw, pcw, pwc, iod, asa, m2r, rw, bne;
      logic [1:0] asb, rd, ps, aop;
      {req, we, irw, pcw, pwc, iod, asa, m2r, rw, bne} = '0;
      {asb, rd, ps, aop} = '0;
      case (st)
         5'd0:  begin req = 1; asb = 2'b01; irw = ack; pcw = ack; end
         5'd1:  asb = 2'b11;
         5'd2:  begin asa = 1; asb = 2'b10; end
         5'd3:  begin req = 1; iod = 1; end
         5'd4:  begin rw = 1; m2r = 1; end
         5'd5:  begin req = 1; we = 1; iod = 1; end
         5'd6:  begin asa = 1; aop = 2'b10; end
         5'd7:  begin rd = 2'b01; rw = 1; end
         5'd8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b10; end
         5'd9:  begin pcw = 1; ps = 2'b01; end
         5'd10: begin rw = 1; rd = 2'b10; end
         5'd11: begin pcw = 1; ps = 2'b01; end
         5'd12: begin pcw = 1; ps = 2'b11; end
         5'd13: begin asa = 1; asb = 2'b10; aop = 2'b11; end
         5'd14: rw = 1;
         5'd15: begin asa = 1; asb = 2'b10; end
         5'd16: rw = 1;
         5'd17: begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b10; bne = 1; end
         default: ;
      endcase
      return {req, we, irw, pcw, pwc, iod, asa, m2r, rw, asb, rd, ps, aop, bne,
              1'(st != 5'd0), 1'(st == 5'd31)};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic [4:0] st, input logic ack, input logic rs);
      item_t it;
      it.st = st; it.ack = ack; it.op = cur_op; it.rs = rs; it.ret = model_ret;
      q.push_back(it);
   endtask

   // Queue one full instruction; trapping instructions stop at the first TRAP cycle.
   task automatic push_instr(input logic [5:0] op, input int fd, input int md);
      logic trapped = 1'b0;
      cur_op = op;
      repeat (fd) push(5'd0, 1'b0, 1'b0);
      push(5'd0, 1'b1, 1'b0);
      push(5'd1, rb(), 1'b0);
      case (op)
         OP_R:    begin push(5'd6, rb(), 0); push(5'd7, rb(), 0); end
         OP_LW:   begin push(5'd2, rb(), 0); repeat (md) push(5'd3, 0, 0);
                        push(5'd3, 1, 0); push(5'd4, rb(), 0); end
         OP_SW:   begin push(5'd2, rb(), 0); repeat (md) push(5'd5, 0, 0); push(5'd5, 1, 0); end
         OP_BEQ:  push(5'd8, rb(), 0);
         OP_J:    push(5'd9, rb(), 0);
         OP_JAL:  begin push(5'd10, rb(), 0); push(5'd11, rb(), 0); end
         OP_JR:   push(5'd12, rb(), 0);
         OP_SLTI: begin push(5'd13, rb(), 0); push(5'd14, rb(), 0); end
         OP_ADDI: begin push(5'd15, rb(), 0); push(5'd16, rb(), 0); end
`ifdef MC_BNE_EN
         OP_BNE:  push(5'd17, rb(), 0);
`endif
         default: begin push(5'd31, rb(), 0); trapped = 1'b1; end
      endcase
      if (!trapped) model_ret = model_ret + CNT_W'(1);
   endtask

   task automatic trap_and_reset(input int hold);
      repeat (hold) push(5'd31, rb(), 1'b0);
      push(5'd31, rb(), 1'b1);
      model_ret = '0;
   endtask

   initial begin
      rst = 1'b1; mem_ack = 1'b0; opcode = '0; func = 6'h2a; zero_in = 1'b0;
      model_ret = '0; cur_op = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", 32'(state), 32'd0);
      check("reset_retired", 32'(retired), 32'd0);
      check("reset_trap", 32'(trap), 32'd0);

      push_instr(OP_LW, 3, 3);
      push_instr(OP_JAL, 0, 0);
      push_instr(OP_R, 1, 0);
      push_instr(OP_SW, 2, 2);
      push_instr(OP_BEQ, 0, 0);
      push_instr(OP_JR, 1, 0);
      push_instr(OP_SLTI, 0, 0);
      push_instr(OP_ADDI, 4, 0);
      push_instr(OP_LW, 0, 4);
      push_instr(OP_J, 2, 0);
      push_instr(OP_BNE, 0, 0);
`ifndef MC_BNE_EN
      trap_and_reset(3);
`endif
      push_instr(OP_BAD, 0, 0);
      trap_and_reset(10);
      cur_op = OP_J;
      repeat (5) push(5'd0, 1'b0, 1'b0);
      trap_and_reset(3);
      cur_op = OP_LW;
      push(5'd0, 1, 0); push(5'd1, rb(), 0); push(5'd2, rb(), 0);
      push(5'd3, 0, 0); push(5'd3, 0, 0); push(5'd3, 0, 1);
      model_ret = '0;
      push_instr(OP_SW, 4, 4);
      for (int i = 0; i < 18; i++) push_instr(OP_J, $urandom_range(0, 2), 0);
      push(5'd0, 1'b0, 1'b0);

      while (q.size() > 0) begin
         item_t it;
         it = q.pop_front();
         rst = it.rs; opcode = it.op; mem_ack = it.ack;
         #1;
         check("state", 32'(state), 32'(it.st));
         check("ctrl", 32'(ctrl), 32'(exp_ctrl(it.st, it.ack)));
         check("retired", 32'(retired), 32'(it.ret));
         @(negedge clk);
      end
      rst = 1'b0; mem_ack = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
